// File: rtl/timeout_bank_pkg.sv
// Shared defaults and types for the timeout bank and its channels.
package timeout_bank_pkg;

   localparam int DEF_N        = 4;
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_SEL_W    = 2;
   localparam int DEF_PRESCALE = 1;

   // What a channel does at a given edge, already resolved by priority.
   typedef enum logic [2:0] {
      EV_IDLE,
      EV_CANCEL,
      EV_START,
      EV_EXPIRE,
      EV_DEC
   } ch_event_e;

   // Prescaler counter width; a prescale of 1 still needs a 1-bit register.
   function automatic int pre_width(input int prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/timeout_bank_channel.sv
// One timeout channel: down-counter, latched mode/reload value, done pulse
// and sticky expiry flag. Advances only on edges where tick is high.
module timeout_bank_channel
   import timeout_bank_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             start,
   input  logic             cancel,
   input  logic             periodic,
   input  logic [WIDTH-1:0] load,
   input  logic             clear_expired,
   output logic             done,
   output logic             busy,
   output logic             expired,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             expired_q, expired_d;
   logic             periodic_q, periodic_d;
   logic [WIDTH-1:0] load_eff;
   logic             set_expired;
   ch_event_e        ev;

   // A load of zero behaves as a load of one so the channel always expires.
   assign load_eff = (load == '0) ? WIDTH'(1) : load;

   // Resolve the per-edge event by priority: cancel, start, expiry, decrement.
   always_comb begin
      ev = EV_IDLE;
      if (cancel)                                      ev = EV_CANCEL;
      else if (start)                                  ev = EV_START;
      else if (busy_q && tick && count_q == WIDTH'(1)) ev = EV_EXPIRE;
      else if (busy_q && tick)                         ev = EV_DEC;
   end

   // Next-state for counter, mode latch, done pulse and sticky flag.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      count_d     = count_q;
      reload_d    = reload_q;
      busy_d      = busy_q;
      periodic_d  = periodic_q;
      done_d      = 1'b0;
      set_expired = 1'b0;
      case (ev)
         EV_CANCEL: begin
            busy_d  = 1'b0;
            count_d = '0;
         end
         EV_START: begin
            count_d    = load_eff;
            reload_d   = load_eff;
            periodic_d = periodic;
            busy_d     = 1'b1;
         end
         EV_EXPIRE: begin
            done_d      = 1'b1;
            set_expired = 1'b1;
            if (periodic_q) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               busy_d  = 1'b0;
            end
         end
         EV_DEC:  count_d = count_q - WIDTH'(1);
         default: ;
      endcase
      // Setting the flag wins over a coincident clear.
      expired_d = set_expired | (expired_q & ~clear_expired);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
      if (rst) begin
         count_q    <= '0;
         reload_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         expired_q  <= 1'b0;
         periodic_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         reload_q   <= reload_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         expired_q  <= expired_d;
         periodic_q <= periodic_d;
      end
   end

   assign done    = done_q;
   assign busy    = busy_q;
   assign expired = expired_q;
   assign count   = count_q;

endmodule

// File: rtl/timeout_bank.sv
// Bank of independent timeout channels sharing one free-running prescaler,
// with a registered readback of a selected channel's remaining count.
module timeout_bank
   import timeout_bank_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int SEL_W    = DEF_SEL_W,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         start,
   input  logic [N-1:0]         cancel,
   input  logic [N-1:0]         periodic,
   input  logic [N*WIDTH-1:0]   timeout,
   input  logic [N-1:0]         clear_expired,
   input  logic [SEL_W-1:0]     rd_sel,
   output logic [N-1:0]         done,
   output logic [N-1:0]         busy,
   output logic [N-1:0]         expired,
   output logic [WIDTH-1:0]     rd_remaining
);

   localparam int               PRE_W   = pre_width(PRESCALE);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick;
   logic [WIDTH-1:0] ch_count [N];
   logic [WIDTH-1:0] rd_q, rd_d;

   // Prescaler wraps at PRESCALE-1; it is never restarted by a channel start.
   assign tick  = (pre_q == PRE_MAX);
   assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
   end

   for (genvar i = 0; i < N; i++) begin : g_ch
      timeout_bank_channel #(.WIDTH(WIDTH)) u_ch (
         .clk           (clk),
         .rst           (rst),
         .tick          (tick),
         .start         (start[i]),
         .cancel        (cancel[i]),
         .periodic      (periodic[i]),
         .load          (timeout[i*WIDTH +: WIDTH]),
         .clear_expired (clear_expired[i]),
         .done          (done[i]),
         .busy          (busy[i]),
         .expired       (expired[i]),
         .count         (ch_count[i])
      );
   end

   // Readback mux; selections past the last channel read zero.
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < N; i++) begin
         if (rd_sel == SEL_W'(i)) rd_d = ch_count[i];
      end
   end

   // Readback register gives the selected count one clock late.
   always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_d;
   end

   assign rd_remaining = rd_q;

endmodule

// File: tb/tb_timeout_bank.sv
// Directed bench for timeout_bank. A deadline-based model (each armed channel
// remembers the edge at which it must fire) predicts every output each cycle;
// literal expectations pin the model against hand-computed latencies.
module tb_timeout_bank;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [N-1:0]   start, cancel, periodic, clr;
   logic [N*W-1:0] tmo;
   logic [SW-1:0]  rd_sel;
   logic [N-1:0]   done, busy, expired;
   logic [W-1:0]   rd;

   // Second instance with a prescaler of 4.
   logic [N-1:0]   start1, zero_n;
   logic [N*W-1:0] tmo1;
   logic [N-1:0]   done1, busy1, expired1;
   logic [W-1:0]   rd1;

   timeout_bank #(.N(N), .WIDTH(W), .SEL_W(SW), .PRESCALE(1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .cancel(cancel), .periodic(periodic),
      .timeout(tmo), .clear_expired(clr), .rd_sel(rd_sel),
      .done(done), .busy(busy), .expired(expired), .rd_remaining(rd)
   );

   timeout_bank #(.N(N), .WIDTH(W), .SEL_W(SW), .PRESCALE(4)) u_dut_pre (
      .clk(clk), .rst(rst), .start(start1), .cancel(zero_n), .periodic(zero_n),
      .timeout(tmo1), .clear_expired(zero_n), .rd_sel(SW'(0)),
      .done(done1), .busy(busy1), .expired(expired1), .rd_remaining(rd1)
   );

   int n_vec = 0;
   int n_bad = 0;
   int k     = 0;

   // Model state
   bit m_act [N];
   bit m_per [N];
   bit m_exp [N];
   bit m_done[N];
   int m_due [N];
   int m_T   [N];
   int m_rd  = 0;

   // Observed done pulses
   int dcnt [N];
   int dlast[N];
   int d1cnt  = 0;
   int d1last = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %0h, expected %0h", name, k, act, exp);
      end
   endtask

   // One clock: advance the model from the inputs seen at this edge, then compare.
   task automatic step();
      int          prev_cnt[N];
      int          t;
      logic [N-1:0] md, mb, me;
      @(posedge clk);
      k++;
      for (int i = 0; i < N; i++) prev_cnt[i] = m_act[i] ? m_due[i] - (k - 1) : 0;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_per[i] = 0; m_exp[i] = 0; m_done[i] = 0; m_due[i] = 0; m_T[i] = 0;
         end
         m_rd = 0;
      end else begin
         m_rd = (int'(rd_sel) < N) ? prev_cnt[int'(rd_sel)] : 0;
         for (int i = 0; i < N; i++) begin
            bit set;
            set = 0;
            m_done[i] = 0;
            if (cancel[i]) begin
               m_act[i] = 0;
            end else if (start[i]) begin
               t = int'(tmo[i*W +: W]);
               if (t == 0) t = 1;
               m_T[i] = t; m_due[i] = k + t; m_act[i] = 1; m_per[i] = periodic[i];
            end else if (m_act[i] && k == m_due[i]) begin
               m_done[i] = 1; set = 1;
               if (m_per[i]) m_due[i] = m_due[i] + m_T[i];
               else          m_act[i] = 0;
            end
            if (set)         m_exp[i] = 1;
            else if (clr[i]) m_exp[i] = 0;
         end
      end
      #1;
      for (int i = 0; i < N; i++) begin
         md[i] = m_done[i]; mb[i] = m_act[i]; me[i] = m_exp[i];
         if (done[i]) begin dcnt[i]++; dlast[i] = k; end
      end
      if (done1[0]) begin d1cnt++; d1last = k; end
      check("done", 32'(done), 32'(md));
      check("busy", 32'(busy), 32'(mb));
      check("expired", 32'(expired), 32'(me));
      check("rd_remaining", 32'(rd), 32'(m_rd));
   endtask

   task automatic run(input int n);
      for (int j = 0; j < n; j++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int s, c;
      for (int i = 0; i < N; i++) begin dcnt[i] = 0; dlast[i] = 0; end
      rst = 1'b1; start = '0; cancel = '0; periodic = '0; clr = '0; tmo = '0; rd_sel = '0;
      start1 = '0; tmo1 = '0; zero_n = '0;

      // Reset state
      run(2);
      rst = 1'b0;
      check("reset_busy", 32'(busy), 0);
      check("reset_expired", 32'(expired), 0);
      check("reset_rd", 32'(rd), 0);

      // One-shot, T=128 on channel 0
      s = k + 1; start[0] = 1; tmo[0*W +: W] = 8'd128;
      step(); start[0] = 0;
      for (int j = 0; j < 129; j++) begin
         step();
         if (done[0]) check("t1_busy_falls_with_done", 32'(busy[0]), 0);
      end
      check("t1_latency", 32'(dlast[0] - s), 128);
      check("t1_pulses", 32'(dcnt[0]), 1);
      check("t1_expired_sticky", 32'(expired[0]), 1);
      clr[0] = 1; step(); clr[0] = 0;
      check("t1_expired_cleared", 32'(expired[0]), 0);

      // T=0 then T=255 on channel 1
      s = k + 1; start[1] = 1; tmo[1*W +: W] = 8'd0;
      step(); start[1] = 0; step();
      check("t2_zero_load_latency", 32'(dlast[1] - s), 1);
      s = k + 1; c = dcnt[1]; start[1] = 1; tmo[1*W +: W] = 8'd255;
      step(); start[1] = 0; run(257);
      check("t2_max_latency", 32'(dlast[1] - s), 255);
      check("t2_max_pulses", 32'(dcnt[1] - c), 1);

      // Periodic T=63 on channel 2 with readback of channel 2
      rd_sel = 2'd2;
      s = k + 1; start[2] = 1; periodic[2] = 1; tmo[2*W +: W] = 8'd63;
      step(); start[2] = 0; periodic[2] = 0;
      c = dcnt[2];
      run(299);
      check("t3_periodic_pulses", 32'(dcnt[2] - c), 4);
      check("t3_last_pulse", 32'(dlast[2] - s), 252);
      cancel[2] = 1; step(); cancel[2] = 0;
      run(70);
      check("t3_no_pulse_after_cancel", 32'(dcnt[2] - c), 4);
      check("t3_idle_after_cancel", 32'(busy[2]), 0);
      rd_sel = 2'd3; run(2);
      check("t3_rd_idle_channel", 32'(rd), 0);

      // Restart on the expiry edge, channel 3
      s = k + 1; start[3] = 1; tmo[3*W +: W] = 8'd10;
      step(); start[3] = 0; run(9);
      c = dcnt[3]; start[3] = 1; tmo[3*W +: W] = 8'd20;
      step(); start[3] = 0;
      check("t4_no_done_at_restart", 32'(done[3]), 0);
      run(20);
      check("t4_single_pulse", 32'(dcnt[3] - c), 1);
      check("t4_restart_latency", 32'(dlast[3] - (s + 10)), 20);

      // Cancel and start together on channel 0
      c = dcnt[0]; cancel[0] = 1; start[0] = 1; tmo[0*W +: W] = 8'd5;
      step(); cancel[0] = 0; start[0] = 0;
      check("t5_cancel_wins", 32'(busy[0]), 0);
      run(8);
      check("t5_no_done", 32'(dcnt[0] - c), 0);

      // Clear coinciding with expiry on channel 1
      clr[1] = 1; step(); clr[1] = 0;
      check("t6_pre_clear", 32'(expired[1]), 0);
      start[1] = 1; tmo[1*W +: W] = 8'd3;
      step(); start[1] = 0; run(2);
      clr[1] = 1; step(); clr[1] = 0;
      check("t6_done_on_edge", 32'(done[1]), 1);
      check("t6_set_wins", 32'(expired[1]), 1);

      // Reset at count 40 of 100 on channel 0
      rd_sel = 2'd0;
      start[0] = 1; tmo[0*W +: W] = 8'd100;
      step(); start[0] = 0; run(60);
      check("t7_mid_count", 32'(rd), 41);
      rst = 1; step(); rst = 0;
      check("t7_rst_done", 32'(done), 0);
      check("t7_rst_busy", 32'(busy), 0);
      check("t7_rst_expired", 32'(expired), 0);
      check("t7_rst_rd", 32'(rd), 0);
      c = dcnt[0]; run(50);
      check("t7_no_late_done", 32'(dcnt[0] - c), 0);

      // Prescaler of 4, T=5
      s = k + 1; start1[0] = 1; tmo1[0*W +: W] = 8'd5;
      step(); start1[0] = 0; run(25);
      check("t8_pre_pulses", 32'(d1cnt), 1);
      check("t8_pre_latency_17_to_20", 32'((d1last - s >= 17) && (d1last - s <= 20)), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/timeout_bank.md
Name: timeout_bank

Overview:
- N-channel generalisation of the single-shot timeout block; each channel is an independent down-counter of WIDTH bits, armed by a start pulse.
- Adds over the single-channel block:
  - periodic (auto-reload) mode
  - cancel
  - sticky expiry flags with clear
  - shared prescaler
  - remaining-count readback
- Sits beside the ranging/echo logic; one channel per transducer or protocol watchdog.

Parameters:
- N, 4, number of channels.
- WIDTH, 8, counter/timeout width in bits.
- SEL_W, 2, width of rd_sel; must satisfy 2**SEL_W >= N.
- PRESCALE, 1, clocks per counter tick (>=1); 1 means decrement every clock.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  N  per-channel arm pulse; sampled each edge.
- cancel  in  N  per-channel abort.
- periodic  in  N  mode, sampled only on the start edge; 1 = auto-reload.
- timeout  in  N*WIDTH  packed load values; channel i uses bits [i*WIDTH +: WIDTH]; sampled only on the start edge.
- clear_expired  in  N  clears sticky flag.
- rd_sel  in  SEL_W  channel selected for readback.
- done  out  N  one-clock expiry pulse, registered.
- busy  out  N  channel counting.
- expired  out  N  sticky expiry flag.
- rd_remaining  out  WIDTH  registered count of channel rd_sel.

Behaviour:
- Reset (rst=1 at an edge): all counters, done, busy, expired, rd_remaining and prescaler = 0; stored mode bits and reload values = 0.
- Tick: free-running prescaler counts 0..PRESCALE-1; tick=1 when it equals PRESCALE-1. PRESCALE=1 gives tick=1 every clock. The prescaler is not restarted by start, so with PRESCALE>1 expiry jitter is up to PRESCALE-1 clocks.
- Per-channel priority at each edge, highest first: rst, cancel, start, expiry, decrement.
- cancel[i]=1: busy=0, count=0, no done; also wins over a simultaneous start.
- start[i]=1 (no cancel):
  - count := T, where a load of 0 is treated as T=1.
  - busy := 1; latch periodic[i] and T.
  - Restarts a busy channel. An expiry that would have occurred on the same edge is suppressed (no done).
- Expiry: busy, tick, count==1.
  - done[i]=1 for exactly one clock; expired[i] := 1.
  - One-shot: count := 0, busy := 0.
  - Periodic: count := latched T, busy stays 1.
- Decrement: busy, tick, count>1 → count-1.
- Latency, PRESCALE=1:
  - done rises T edges after the start edge.
  - Periodic repeats every T clocks.
  - busy falls on the same edge done rises (one-shot).
- expired[i] is sticky until clear_expired[i]. If set and clear coincide, set wins (flag stays 1).
- rd_remaining is registered: the count of channel rd_sel as of the previous edge, so one-clock latency. rd_sel >= N reads 0.
- Reset mid-count: the channel returns to idle immediately; no done is generated.
- Channels are fully independent; simultaneous events on different channels never interact.
- No arithmetic wrap: count never decrements below 1 while busy.

Decomposition:
- Shared include timeout_defs.vh holds default WIDTH/N/PRESCALE and SEL_W helper constants.
- Natural sub-module timeout_channel: one counter, mode latch, done/expired logic, with tick as an input.
- timeout_bank contains:
  - the prescaler
  - a generate loop of N timeout_channel instances
  - the readback mux

Test Plan:
- Defaults, reset then start[0] with T=128, one-shot → done[0] high exactly one clock 128 edges after the start edge; busy[0] falls on that edge; expired[0]=1 until clear_expired[0].
- T=0 on channel 1 → done[1] one edge after start; T=255 → done after 255 edges; no wrap.
- Periodic, channel 2, T=63, held 300 clocks → done[2] pulses at 63, 126, 189, 252; then cancel → no further done, busy[2]=0.
- start on channel 3 at the expiry edge (T=10, restart with T=20) → no done at 10; done at 20 edges after the restart.
- Cancel and start on the same edge → channel idle. clear_expired and expiry on the same edge → expired stays 1. rst at count 40 of 100 → all outputs 0, no done.
- PRESCALE=4, T=5 → done within 17..20 clocks of start. rd_sel=2 during the count → rd_remaining tracks channel 2 with one-clock lag; rd_sel=3 idle → 0.
